// File: rtl/mem_access_unit.sv
// mem_access_unit
// Owns the LC-3 MAR/MDR pair and runs one timed SRAM access at a time.
// A request in IDLE latches the access type and preloads the wait counter;
// the block then holds ACCESS for WAIT_STATES+1 cycles and spends one cycle
// in DONE (R=1) before returning to IDLE. Read data lands in MDR on the
// edge that leaves ACCESS.
//
// Ports
//   Clk, Reset_n            clock, async active-low reset
//   BUS                     shared datapath bus (MAR/MDR load source)
//   LD_MAR, LD_MDR          register loads, honoured outside ACCESS only
//   Mem_Req, Mem_Write      access start / type, sampled in IDLE only
//   MEM_RDATA               SRAM read data
//   MAR, MDR                address / data registers
//   MEM_ADDR, MEM_WDATA     SRAM address / write data (mirror MAR / MDR)
//   MEM_CE_N/OE_N/WE_N      active-low SRAM strobes, decoded from state
//   R                       one-cycle completion pulse (DONE)
//   Busy                    state != IDLE
module mem_access_unit #(
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] BUS,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        Mem_Req,
  input  logic        Mem_Write,
  input  logic [15:0] MEM_RDATA,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic        MEM_CE_N,
  output logic        MEM_OE_N,
  output logic        MEM_WE_N,
  output logic        R,
  output logic        Busy
);

  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       is_write;
  logic       ld_ok;

  // Address and write data must stay frozen while the SRAM is strobed.
  assign ld_ok = (state != ACCESS);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      is_write <= 1'b0;
      MAR      <= 16'h0000;
      MDR      <= 16'h0000;
    end else begin
      // Loads share the edge with a request in IDLE; the access then sees
      // the new values from its first cycle since the SRAM is driven from
      // the registers themselves.
      if (ld_ok && LD_MAR) MAR <= BUS;
      if (ld_ok && LD_MDR) MDR <= BUS;
      case (state)
        IDLE: begin
          if (Mem_Req) begin
            is_write <= Mem_Write;
            cnt      <= WS4;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            if (!is_write) MDR <= MEM_RDATA;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign MEM_CE_N  = (state != ACCESS);
  assign MEM_OE_N  = !((state == ACCESS) && !is_write);
  assign MEM_WE_N  = !((state == ACCESS) &&  is_write);
  assign R         = (state == DONE);
  assign Busy      = (state != IDLE);
  assign MEM_ADDR  = MAR;
  assign MEM_WDATA = MDR;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus, rdata;
  logic        ld_mar, ld_mdr, wr;
  logic        req2, req0, req15;

  // WAIT_STATES=2 instance
  logic [15:0] mar2, mdr2, addr2, wdata2;
  logic        ce2, oe2, we2, r2, busy2;
  // WAIT_STATES=0 instance
  logic [15:0] mar0, mdr0, addr0, wdata0;
  logic        ce0, oe0, we0, r0, busy0;
  // WAIT_STATES=15 instance
  logic [15:0] mar15, mdr15, addr15, wdata15;
  logic        ce15, oe15, we15, r15, busy15;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WAIT_STATES(2)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .BUS(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .Mem_Req(req2), .Mem_Write(wr), .MEM_RDATA(rdata),
    .MAR(mar2), .MDR(mdr2), .MEM_ADDR(addr2), .MEM_WDATA(wdata2),
    .MEM_CE_N(ce2), .MEM_OE_N(oe2), .MEM_WE_N(we2), .R(r2), .Busy(busy2));

  mem_access_unit #(.WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .BUS(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .Mem_Req(req0), .Mem_Write(wr), .MEM_RDATA(rdata),
    .MAR(mar0), .MDR(mdr0), .MEM_ADDR(addr0), .MEM_WDATA(wdata0),
    .MEM_CE_N(ce0), .MEM_OE_N(oe0), .MEM_WE_N(we0), .R(r0), .Busy(busy0));

  mem_access_unit #(.WAIT_STATES(15)) dut15 (
    .Clk(clk), .Reset_n(rst_n), .BUS(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
    .Mem_Req(req15), .Mem_Write(wr), .MEM_RDATA(rdata),
    .MAR(mar15), .MDR(mdr15), .MEM_ADDR(addr15), .MEM_WDATA(wdata15),
    .MEM_CE_N(ce15), .MEM_OE_N(oe15), .MEM_WE_N(we15), .R(r15), .Busy(busy15));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // strobes packed as {CE_N, OE_N, WE_N, R, Busy}
  function automatic logic [15:0] st2();
    return {11'd0, ce2, oe2, we2, r2, busy2};
  endfunction

  // Advance one edge and settle just past it; outputs depend on state only.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; bus = 16'h0; rdata = 16'h0;
    ld_mar = 1'b0; ld_mdr = 1'b0; wr = 1'b0;
    req2 = 1'b0; req0 = 1'b0; req15 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset / idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_mar", mar2, 16'h0000);
      chk("idle_mdr", mdr2, 16'h0000);
      chk("idle_strb", st2(), 16'b11100);
    end

    // Read, WAIT_STATES=2
    bus = 16'h3000; ld_mar = 1'b1;
    tick();
    chk("rd_mar", mar2, 16'h3000);
    ld_mar = 1'b0; req2 = 1'b1; wr = 1'b0; rdata = 16'hBEEF;
    tick();                                   // request edge k
    chk("rd_acc1", st2(), 16'b00101);
    req2 = 1'b0;
    // loads and a second request during ACCESS are ignored
    bus = 16'hFFFF; ld_mar = 1'b1; ld_mdr = 1'b1; req2 = 1'b1;
    tick();
    chk("rd_acc2", st2(), 16'b00101);
    chk("rd_mar_hold", addr2, 16'h3000);
    chk("rd_mdr_hold", mdr2, 16'h0000);
    ld_mar = 1'b0; ld_mdr = 1'b0; req2 = 1'b0;
    tick();
    chk("rd_acc3", st2(), 16'b00101);
    tick();                                   // k+3: DONE
    chk("rd_done", st2(), 16'b11111);
    chk("rd_mdr", mdr2, 16'hBEEF);
    chk("rd_mar_end", mar2, 16'h3000);
    tick();
    chk("rd_idle", st2(), 16'b11100);
    chk("rd_mdr_keep", mdr2, 16'hBEEF);
    tick();
    chk("rd_no_2nd", st2(), 16'b11100);

    // Write with simultaneous MDR load
    bus = 16'h1234; ld_mdr = 1'b1; req2 = 1'b1; wr = 1'b1; rdata = 16'hDEAD;
    tick();
    ld_mdr = 1'b0; req2 = 1'b0; wr = 1'b0; bus = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      chk("wr_acc", st2(), 16'b01001);
      chk("wr_wdata", wdata2, 16'h1234);
      tick();
    end
    chk("wr_done", st2(), 16'b11111);
    chk("wr_mdr", mdr2, 16'h1234);
    tick();
    chk("wr_idle", st2(), 16'b11100);
    chk("wr_mdr_keep", mdr2, 16'h1234);

    // WAIT_STATES=0
    req0 = 1'b1; wr = 1'b0; rdata = 16'h5A5A;
    tick();
    req0 = 1'b0;
    chk("ws0_acc", {ce0, oe0, we0, r0, busy0}, 16'b00101);
    tick();
    chk("ws0_done", {ce0, oe0, we0, r0, busy0}, 16'b11111);
    chk("ws0_mdr", mdr0, 16'h5A5A);
    tick();
    chk("ws0_idle", {ce0, oe0, we0, r0, busy0}, 16'b11100);

    // WAIT_STATES=15: 16 ACCESS cycles, then DONE, then IDLE
    req15 = 1'b1; rdata = 16'hC0DE;
    tick();
    req15 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("ws15_acc", {ce15, oe15, we15, r15, busy15}, 16'b00101);
      tick();
    end
    chk("ws15_done", {ce15, oe15, we15, r15, busy15}, 16'b11111);
    chk("ws15_mdr", mdr15, 16'hC0DE);
    tick();
    chk("ws15_idle", {ce15, oe15, we15, r15, busy15}, 16'b11100);

    // Reset in the second ACCESS cycle of a read
    req2 = 1'b1; wr = 1'b0; rdata = 16'h7777;
    tick();
    req2 = 1'b0;
    tick();
    chk("rst_acc2", st2(), 16'b00101);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", st2(), 16'b11100);
    chk("rst_mdr", mdr2, 16'h0000);
    chk("rst_mar", mar2, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_noR", st2(), 16'b11100);
    end
    rst_n = 1'b1;
    tick();
    chk("rst_idle", st2(), 16'b11100);
    chk("rst_mdr2", mdr2, 16'h0000);
    req2 = 1'b1;
    tick();
    req2 = 1'b0;
    chk("rst_newreq", st2(), 16'b00101);
    tick(); tick(); tick();
    chk("rst_new_done", st2(), 16'b11111);
    chk("rst_new_mdr", mdr2, 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
